sync_fifo_param: RTL and testbench
==================================

Name: sync_fifo_param

Overview:
- Parametrised single-clock FIFO; successor to the fixed 8-bit×16 FIFO.
- Generalised width/depth; uses full DEPTH capacity (no lost slot); supports simultaneous read+write.
- Adds occupancy count, almost-full/almost-empty thresholds, sticky overflow/underflow flags, registered read-data valid.
- Sits between producer/consumer stages in the same clock domain.

Parameters:
- WIDTH, 8, data word width in bits (≥1)
- DEPTH, 16, number of entries; power of 2, ≥4
- AF_THRESH, DEPTH-2, almost_full asserts when count ≥ AF_THRESH
- AE_THRESH, 2, almost_empty asserts when count ≤ AE_THRESH

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- wr_en  in  1  write request
- din  in  WIDTH  write data
- rd_en  in  1  read request
- dout  out  WIDTH  read data
- dout_valid  out  1  dout holds newly popped word this cycle
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count ≥ AF_THRESH
- almost_empty  out  1  count ≤ AE_THRESH
- count  out  $clog2(DEPTH)+1  current occupancy
- overflow  out  1  sticky: write attempted while full
- underflow  out  1  sticky: read attempted while empty
- clr_err  in  1  clears overflow/underflow

Behaviour:
- Reset (rst=1 at edge): wptr=0, rptr=0, count=0, dout=0, dout_valid=0, overflow=0, underflow=0. Memory contents are not reset. rst overrides all other inputs, including mid-operation.
- Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0 (no explicit compare).
- All flags are combinational from registered count: full, empty, almost_full, almost_empty.
- Write accept: wr_acc = wr_en && !full. On accept: mem[wptr]<=din, wptr++.
- Read accept: rd_acc = rd_en && !empty. On accept: dout<=mem[rptr], rptr++, dout_valid<=1. Otherwise dout_valid<=0 and dout holds its value.
- Read latency: 1 cycle from rd_en to dout/dout_valid.
- count update: +1 on write only, −1 on read only, unchanged when both accepted.
- Simultaneous rd+wr:
  - When full: read accepted, write rejected (flag evaluated pre-edge).
  - When empty: write accepted, read rejected; underflow sets.
- Errors:
  - overflow<=1 when wr_en && full; underflow<=1 when rd_en && empty.
  - Both hold until rst or clr_err.
  - If clr_err and a new error occur in the same cycle, the set wins.
- Rejected operations leave pointers, count and memory unchanged.
- Write-to-read visibility: a word written at edge N is readable by rd_en sampled at edge N+1.

Optional Feature:
- Macro: SYNC_FIFO_FWFT_EN
- Defined (first-word-fall-through):
  - dout continuously presents mem[rptr]; dout_valid = !empty.
  - rd_en acts as a pop/acknowledge: rptr advances, and the next word appears the same cycle after the edge.
  - Zero read latency.
- Undefined: standard mode as above, with 1-cycle registered dout.
- Flags, count and error behaviour are identical in both modes.

Decomposition:
- Package sync_fifo_pkg holds:
  - function clog2-based width helpers (ADDR_W, CNT_W derivation)
  - typedef for the error-status struct {overflow, underflow}
- One sub-module: fifo_mem_2p, a parametrised WIDTH×DEPTH register array.
  - Sync write port; async read port; registered in the top in standard mode.
- Pointer/count/flag control stays in the top module.

Test Plan (WIDTH=8, DEPTH=16, AF=14, AE=2):
- Reset then idle → empty=1, full=0, count=0, dout=0, dout_valid=0, overflow=underflow=0.
- Write 16 words 0x10..0x1F → full=1 after 16th edge, count=16, almost_full from count=14; 17th write (0xAA) → overflow=1, count stays 16, no data corrupted.
- Read 16 words → dout sequence 0x10..0x1F, each one cycle after rd_en with dout_valid=1; then empty=1; extra rd_en → underflow=1, dout_valid=0, dout stays 0x1F.
- Fill to 8, then rd_en+wr_en together for 20 cycles → count stays 8, in-order data across pointer wrap, no flags set.
- Partway through filling (count=5), assert rst → next cycle count=0, empty=1, pointers 0; subsequent write/read returns the new data only.
- Set overflow, pulse clr_err → overflow=0; clr_err coincident with wr_en while full → overflow stays 1.

Source files
------------

// File: rtl/sync_fifo_pkg.sv
// Shared helpers and types for the parametrised synchronous FIFO.
// Pointer and occupancy widths are derived here so every file sizes them the same way.
package sync_fifo_pkg;

  // Pointer width. A DEPTH of 1 would give zero bits, so the result is floored at one.
  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Occupancy width. It has one extra bit so that count can hold DEPTH itself.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  typedef struct packed {
    logic overflow;
    logic underflow;
  } err_status_t;

endpackage

// File: rtl/fifo_mem_2p.sv
// WIDTH x DEPTH register array with one synchronous write port and one asynchronous read port.
// Any output registering is left to the instantiating FIFO.
module fifo_mem_2p #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: the array has no reset. Clearing every entry would cost a mux per bit, and the FIFO
  // never reads a slot before writing it.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, threshold flags and sticky error flags.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through output. The default build registers dout.
module sync_fifo_param
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         din,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         dout,
  output logic                     dout_valid,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [cnt_w(DEPTH)-1:0]  count,
  output logic                     overflow,
  output logic                     underflow,
  input  logic                     clr_err
);

  localparam int ADDR_W = addr_w(DEPTH);
  localparam int CNT_W  = cnt_w(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_CNT   = CNT_W'(AF_THRESH);
  localparam logic [CNT_W-1:0] AE_CNT   = CNT_W'(AE_THRESH);

  logic [ADDR_W-1:0] wptr;
  logic [ADDR_W-1:0] rptr;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  err_status_t       err_q;
  err_status_t       err_d;
  logic              wr_acc;
  logic              rd_acc;
  logic [WIDTH-1:0]  rdata;

  // All flags come from the registered count. Accept decisions therefore use pre-edge state.
  assign full         = (cnt_q == FULL_CNT);
  assign empty        = (cnt_q == '0);
  assign almost_full  = (cnt_q >= AF_CNT);
  assign almost_empty = (cnt_q <= AE_CNT);
  assign count        = cnt_q;
  assign overflow     = err_q.overflow;
  assign underflow    = err_q.underflow;

  assign wr_acc = wr_en && !full;
  assign rd_acc = rd_en && !empty;

  // NOTE: always_comb assigns each output a default first, so no path can leave a latch behind.
  always_comb begin
    cnt_d = cnt_q;
    unique case ({wr_acc, rd_acc})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase

    // A new error and clr_err in the same cycle leaves the flag set.
    err_d.overflow  = (wr_en && full)  || (err_q.overflow  && !clr_err);
    err_d.underflow = (rd_en && empty) || (err_q.underflow && !clr_err);
  end

  // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      cnt_q <= '0;
      err_q <= '0;
    end else begin
      // The pointers are exactly ADDR_W bits wide, so DEPTH-1 wraps to 0 without a compare.
      if (wr_acc) wptr <= wptr + ADDR_W'(1);
      if (rd_acc) rptr <= rptr + ADDR_W'(1);
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  fifo_mem_2p #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wptr),
    .wdata (din),
    .raddr (rptr),
    .rdata (rdata)
  );

`ifdef SYNC_FIFO_FWFT_EN
  // The head word is always on dout. rd_en only acknowledges it and moves rptr on.
  assign dout       = rdata;
  assign dout_valid = !empty;
`else
  logic [WIDTH-1:0] dout_q;
  logic             dout_valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      dout_valid_q <= rd_acc;
      if (rd_acc) dout_q <= rdata;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Scoreboard bench for sync_fifo_param in standard mode (WIDTH=8, DEPTH=16, AF=14, AE=2).
// Stimulus pushes the expected read data into a queue, and a negedge monitor pops it and compares.
module tb_sync_fifo_param;

  localparam int W  = 8;
  localparam int D  = 16;
  localparam int AF = 14;
  localparam int AE = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         wr_en;
  logic [W-1:0] din;
  logic         rd_en;
  logic [W-1:0] dout;
  logic         dout_valid;
  logic         full;
  logic         empty;
  logic         almost_full;
  logic         almost_empty;
  logic [4:0]   count;
  logic         overflow;
  logic         underflow;
  logic         clr_err;

  int           n_checks = 0;
  int           n_fail   = 0;
  logic [W-1:0] model_q[$];
  logic [W-1:0] exp_q[$];
  logic         ov_m = 1'b0;
  logic         un_m = 1'b0;

  always #5 clk = ~clk;

  sync_fifo_param #(
    .WIDTH     (W),
    .DEPTH     (D),
    .AF_THRESH (AF),
    .AE_THRESH (AE)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .din          (din),
    .rd_en        (rd_en),
    .dout         (dout),
    .dout_valid   (dout_valid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow),
    .clr_err      (clr_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus. Inputs change at the negedge and outputs are checked at the next negedge.
  task automatic cycle(input logic w, input logic [W-1:0] d, input logic r, input logic c);
    int   sz;
    logic wr_ok;
    logic rd_ok;
    sz    = model_q.size();
    wr_ok = w && (sz < D);
    rd_ok = r && (sz > 0);
    ov_m  = (w && (sz == D)) || (ov_m && !c);
    un_m  = (r && (sz == 0)) || (un_m && !c);
    if (rd_ok) exp_q.push_back(model_q.pop_front());
    if (wr_ok) model_q.push_back(d);
    wr_en   = w;
    din     = d;
    rd_en   = r;
    clr_err = c;
    @(negedge clk);
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    clr_err = 1'b0;
    din     = '0;
    sz = model_q.size();
    check("count",        count,        sz);
    check("full",         full,         sz == D);
    check("empty",        empty,        sz == 0);
    check("almost_full",  almost_full,  sz >= AF);
    check("almost_empty", almost_empty, sz <= AE);
    check("dout_valid",   dout_valid,   rd_ok);
    check("overflow",     overflow,     ov_m);
    check("underflow",    underflow,    un_m);
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    clr_err = 1'b0;
    din     = '0;
    @(negedge clk);
    rst = 1'b0;
    model_q.delete();
    exp_q.delete();
    ov_m = 1'b0;
    un_m = 1'b0;
  endtask

  // The monitor compares every word the DUT presents against the scoreboard.
  always @(negedge clk) begin
    if (!rst && dout_valid) begin
      if (exp_q.size() > 0) check("dout", dout, exp_q.pop_front());
      else                  check("dout_valid_unexpected", dout_valid, 1'b0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst     = 1'b1;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    clr_err = 1'b0;
    din     = '0;
    repeat (2) @(negedge clk);
    do_reset();

    // Reset and idle state
    check("rst_empty",     empty,      1);
    check("rst_full",      full,       0);
    check("rst_count",     count,      0);
    check("rst_dout",      dout,       8'h00);
    check("rst_dout_vld",  dout_valid, 0);
    check("rst_overflow",  overflow,   0);
    check("rst_underflow", underflow,  0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);

    // Fill 0x10..0x1F, then write once more while full
    for (int i = 0; i < D; i++) cycle(1'b1, W'(8'h10 + i), 1'b0, 1'b0);
    check("fill_count", count, 16);
    check("fill_full",  full,  1);
    cycle(1'b1, 8'hAA, 1'b0, 1'b0);
    check("ovf_set",   overflow, 1);
    check("ovf_count", count,    16);

    // Drain all 16 words, then read once more while empty
    for (int i = 0; i < D; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    check("drain_empty", empty, 1);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    check("udf_set",      underflow,  1);
    check("udf_dout_vld", dout_valid, 0);
    check("udf_dout",     dout,       8'h1F);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    check("clr_both_ovf", overflow,  0);
    check("clr_both_udf", underflow, 0);

    // Fill to 8, then 20 cycles of simultaneous read and write across the pointer wrap
    for (int i = 0; i < 8; i++)  cycle(1'b1, W'(8'h20 + i), 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) cycle(1'b1, W'(8'h30 + i), 1'b1, 1'b0);
    check("rw_count", count,     8);
    check("rw_ovf",   overflow,  0);
    check("rw_udf",   underflow, 0);
    for (int i = 0; i < 8; i++)  cycle(1'b0, 8'h00, 1'b1, 1'b0);
    check("rw_last_dout", dout, 8'h43);

    // Reset in the middle of filling
    for (int i = 0; i < 5; i++) cycle(1'b1, W'(8'h50 + i), 1'b0, 1'b0);
    check("pre_rst_count", count, 5);
    do_reset();
    check("mid_rst_count", count, 0);
    check("mid_rst_empty", empty, 1);
    check("mid_rst_dout",  dout,  8'h00);
    cycle(1'b1, 8'h77, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    check("post_rst_dout", dout, 8'h77);

    // clr_err alone clears the flag, but a new overflow in the same cycle wins
    for (int i = 0; i < D; i++) cycle(1'b1, W'(8'h80 + i), 1'b0, 1'b0);
    cycle(1'b1, 8'hAA, 1'b0, 1'b0);
    check("ovf2_set", overflow, 1);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    check("ovf2_clr", overflow, 0);
    cycle(1'b1, 8'hBB, 1'b0, 1'b1);
    check("ovf2_set_wins", overflow, 1);
    check("ovf2_count",    count,    16);
    for (int i = 0; i < D; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    check("ovf2_last_dout", dout, 8'h8F);

    repeat (2) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
